atcm_mult_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-stage ATCM wrapper.
- Multiplies two W-bit unsigned operands, exact or approximate (per transaction), behind a valid/ready stream interface with backpressure.
- Carries the exact product alongside and keeps running error statistics for on-board accuracy characterisation.
- Sits between the stimulus source and the result capture logic, in the same clock domain.

---
 rtl/atcm_pkg.sv | 30 +++
 rtl/atcm_approx_core.sv | 34 +++
 rtl/atcm_mult_pipe.sv | 101 ++++++++++
 tb/tb_atcm_mult_pipe.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/atcm_pkg.sv
// Shared constants and arithmetic helpers for the ATCM multiplier family.
// Helpers use 64-bit arguments so one definition serves every counter width up to 63 bits.
package atcm_pkg;

    localparam int DEF_W      = 8;
    localparam int DEF_K      = 4;
    localparam int DEF_STAGES = 2;
    localparam int DEF_ACC_W  = 32;
    localparam int DEF_CNT_W  = 24;

    // Sum clamped to the all-ones value of a width-bit counter.
    function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                            input logic [63:0] inc,
                                            input int          width);
        logic [64:0] sum;
        logic [64:0] lim;
        sum = {1'b0, acc} + {1'b0, inc};
        lim = (65'd1 << width) - 65'd1;
        if (sum > lim) begin
            return lim[63:0];
        end
        return sum[63:0];
    endfunction

    function automatic logic [63:0] abs_diff(input logic [63:0] x,
                                             input logic [63:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/atcm_approx_core.sv
// Combinational exact and approximate products; columns below K are replaced by an OR of
// their partial products, columns at or above K are summed exactly with no carry-in from below.
module atcm_approx_core #(
    parameter int W = 8,
    parameter int K = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic [2*W-1:0] z_approx,
    output logic [2*W-1:0] z_exact
);

    logic [2*W-1:0] hi;
    logic [2*W-1:0] lo;

    always_comb begin
        hi = '0;
        lo = '0;
        for (int i = 0; i < W; i++) begin
            for (int j = 0; j < W; j++) begin
                if (i + j >= K) begin
                    hi = hi + ((2*W)'(a[i] & b[j]) << (i + j));
                end else begin
                    lo[i+j] = lo[i+j] | (a[i] & b[j]);
                end
            end
        end
    end

    // hi has nothing below bit K and lo nothing at or above it
    assign z_approx = hi | lo;
    assign z_exact  = (2*W)'(a) * (2*W)'(b);

endmodule

// File: rtl/atcm_mult_pipe.sv
// Pipelined exact/approximate multiplier with valid/ready handshake and running error statistics.
// Stage 1 registers operands, stage 2 registers both products, later stages only carry them.
module atcm_mult_pipe
    import atcm_pkg::*;
#(
    parameter int W      = DEF_W,
    parameter int K      = DEF_K,
    parameter int STAGES = DEF_STAGES,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     a_in,
    input  logic [W-1:0]     b_in,
    input  logic             mode_approx,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   z_out,
    output logic [2*W-1:0]   z_exact_out,
    input  logic             stats_clr,
    output logic [ACC_W-1:0] err_acc,
    output logic [CNT_W-1:0] sample_cnt
);

    localparam int ZW = 2 * W;

    logic          adv;
    logic          dlv;
    logic          s1_valid;
    logic          s1_mode;
    logic [W-1:0]  s1_a;
    logic [W-1:0]  s1_b;
    logic [ZW-1:0] core_za;
    logic [ZW-1:0] core_zx;
    logic          pv [2:STAGES];
    logic [ZW-1:0] pz [2:STAGES];
    logic [ZW-1:0] px [2:STAGES];
    logic [63:0]   err;

    atcm_approx_core #(
        .W (W),
        .K (K)
    ) u_core (
        .a        (s1_a),
        .b        (s1_b),
        .z_approx (core_za),
        .z_exact  (core_zx)
    );

    // One global enable: the whole pipe moves or the whole pipe holds.
    assign adv         = !out_valid || out_ready;
    assign in_ready    = adv;
    assign dlv         = out_valid && out_ready;
    assign out_valid   = pv[STAGES];
    assign z_out       = pz[STAGES];
    assign z_exact_out = px[STAGES];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_mode  <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            for (int k = 2; k <= STAGES; k++) begin
                pv[k] <= 1'b0;
                pz[k] <= '0;
                px[k] <= '0;
            end
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_mode  <= mode_approx;
            s1_a     <= a_in;
            s1_b     <= b_in;
            pv[2]    <= s1_valid;
            pz[2]    <= s1_mode ? core_za : core_zx;
            px[2]    <= core_zx;
            for (int k = 3; k <= STAGES; k++) begin
                pv[k] <= pv[k-1];
                pz[k] <= pz[k-1];
                px[k] <= px[k-1];
            end
        end
    end

    // Exact-mode results carry z_out == z_exact_out, so their error is naturally zero.
    assign err = abs_diff(64'(z_exact_out), 64'(z_out));

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            err_acc    <= '0;
            sample_cnt <= '0;
        end else if (dlv) begin
            err_acc    <= ACC_W'(sat_add(64'(err_acc), err, ACC_W));
            sample_cnt <= CNT_W'(sat_add(64'(sample_cnt), 64'd1, CNT_W));
        end
    end

endmodule

// File: tb/tb_atcm_mult_pipe.sv
// Randomized and directed checks of atcm_mult_pipe against a column-count product model
// and a queue-based in-order scoreboard with saturating statistics.
module tb_atcm_mult_pipe;

    localparam int W      = 8;
    localparam int K      = 4;
    localparam int STAGES = 3;
    localparam int ACC_W  = 12;
    localparam int CNT_W  = 4;
    localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;
    localparam longint CNT_MAX = (64'd1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic             mode_approx;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   z_out;
    logic [2*W-1:0]   z_exact_out;
    logic             stats_clr;
    logic [ACC_W-1:0] err_acc;
    logic [CNT_W-1:0] sample_cnt;

    atcm_mult_pipe #(
        .W (W), .K (K), .STAGES (STAGES), .ACC_W (ACC_W), .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a_in        (a_in),
        .b_in        (b_in),
        .mode_approx (mode_approx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .z_out       (z_out),
        .z_exact_out (z_exact_out),
        .stats_clr   (stats_clr),
        .err_acc     (err_acc),
        .sample_cnt  (sample_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Approximate product from column populations: exact weight for columns >= K, OR below.
    function automatic longint ref_approx(input int a, input int b);
        longint r;
        int     n;
        r = 0;
        for (int c = 0; c < 2*W; c++) begin
            n = 0;
            for (int i = 0; i < W; i++) begin
                if (c - i >= 0 && c - i < W) begin
                    n += ((a >> i) & 1) * ((b >> (c - i)) & 1);
                end
            end
            if (c >= K) r += longint'(n) << c;
            else if (n != 0) r += longint'(1) << c;
        end
        return r % (longint'(1) << (2*W));
    endfunction

    typedef struct { longint z; longint zx; } exp_t;
    exp_t   q[$];
    longint acc_m = 0;
    longint cnt_m = 0;
    bit     armed = 0;
    bit     stall_prev = 0;
    logic [2*W-1:0] held_z;
    longint last_z, last_zx;
    int     cyc = 0;
    int     dlv_count = 0;
    bit     stream_arm = 0;
    int     first_acc = -1, first_ov = -1, last_ov = -1, ir_low = 0;

    always @(posedge clk) cyc++;

    // Monitor: handshakes are stable at the falling edge and take effect on the next rising edge.
    always @(negedge clk) begin
        exp_t   e;
        longint a_i, b_i, err;
        if (armed) begin
            if (rst) begin
                q.delete();
                acc_m = 0;
                cnt_m = 0;
                stall_prev = 0;
            end else begin
                check("err_acc", 64'(err_acc), 64'(acc_m));
                check("sample_cnt", 64'(sample_cnt), 64'(cnt_m));
                if (stall_prev && out_valid) check("hold_z", 64'(z_out), 64'(held_z));
                if (out_valid && !out_ready) check("ready_bp", 64'(in_ready), 64'(0));
                stall_prev = out_valid && !out_ready;
                held_z = z_out;
                if (stream_arm) begin
                    if (!in_ready) ir_low++;
                    if (out_valid) begin
                        if (first_ov < 0) first_ov = cyc;
                        last_ov = cyc;
                    end
                end
                if (in_valid && in_ready) begin
                    a_i = longint'(a_in);
                    b_i = longint'(b_in);
                    e.zx = a_i * b_i;
                    e.z  = mode_approx ? ref_approx(int'(a_in), int'(b_in)) : e.zx;
                    q.push_back(e);
                    if (stream_arm && first_acc < 0) first_acc = cyc;
                end
                if (out_valid && out_ready) begin
                    dlv_count++;
                    if (q.size() == 0) begin
                        check("spurious_dlv", 64'(out_valid), 64'(0));
                    end else begin
                        e = q.pop_front();
                        check("z_out", 64'(z_out), 64'(e.z));
                        check("z_exact_out", 64'(z_exact_out), 64'(e.zx));
                        last_z  = e.z;
                        last_zx = e.zx;
                        err = (e.zx > e.z) ? e.zx - e.z : e.z - e.zx;
                        acc_m = (acc_m + err > ACC_MAX) ? ACC_MAX : acc_m + err;
                        cnt_m = (cnt_m + 1 > CNT_MAX) ? CNT_MAX : cnt_m + 1;
                    end
                end
                if (stats_clr) begin
                    acc_m = 0;
                    cnt_m = 0;
                end
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
        bit ok;
        ok = 0;
        a_in = a;
        b_in = b;
        mode_approx = m;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1;
        end
        if (!ok) check("send_timeout", 64'(in_ready), 64'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_empty", 64'(q.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        stats_clr = 1'b1;
        @(posedge clk);
        #1;
        stats_clr = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int  d0;
        bit  done;
        rst = 1'b1;
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        mode_approx = 1'b0;
        out_ready = 1'b0;
        stats_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_z_out", 64'(z_out), 64'(0));
        check("rst_z_exact", 64'(z_exact_out), 64'(0));
        check("rst_err_acc", 64'(err_acc), 64'(0));
        check("rst_sample_cnt", 64'(sample_cnt), 64'(0));
        armed = 1;

        // Directed products
        out_ready = 1'b1;
        send(8'd15, 8'd15, 1'b1);
        drain();
        check("z_15x15_apx", 64'(last_z), 64'(191));
        check("zx_15x15", 64'(last_zx), 64'(225));
        check("acc_after_15x15", 64'(err_acc), 64'(34));
        check("cnt_after_15x15", 64'(sample_cnt), 64'(1));
        send(8'd255, 8'd255, 1'b0);
        drain();
        check("z_255x255_ex", 64'(last_z), 64'(65025));
        check("zx_255x255", 64'(last_zx), 64'(65025));
        check("acc_after_exact", 64'(err_acc), 64'(34));
        check("cnt_after_exact", 64'(sample_cnt), 64'(2));
        send(8'd0, 8'd200, 1'b1);
        drain();
        check("z_0x200_apx", 64'(last_z), 64'(0));
        check("acc_after_zero", 64'(err_acc), 64'(34));
        check("cnt_after_zero", 64'(sample_cnt), 64'(3));

        // Back-to-back stream
        d0 = dlv_count;
        stream_arm = 1;
        for (int i = 0; i < 10; i++) send(W'(i * 23 + 7), W'(255 - i * 11), 1'(i % 2));
        drain();
        stream_arm = 0;
        check("stream_latency", 64'(first_ov - first_acc), 64'(STAGES));
        check("stream_consecutive", 64'(last_ov - first_ov), 64'(9));
        check("stream_in_ready_low", 64'(ir_low), 64'(0));
        check("stream_dlv", 64'(dlv_count - d0), 64'(10));

        // Backpressure mid-stream
        d0 = dlv_count;
        fork
            for (int i = 0; i < 8; i++) send(W'($urandom_range(255)), W'($urandom_range(255)), 1'b1);
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1;
                check("bp_in_ready", 64'(in_ready), 64'(0));
                check("bp_out_valid", 64'(out_valid), 64'(1));
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("bp_dlv", 64'(dlv_count - d0), 64'(8));

        // Counter saturation and clear
        pulse_clr();
        check("clr_err_acc", 64'(err_acc), 64'(0));
        check("clr_sample_cnt", 64'(sample_cnt), 64'(0));
        for (int i = 0; i < 20; i++) send(W'($urandom_range(255)), W'($urandom_range(255)), 1'b1);
        drain();
        check("cnt_saturated", 64'(sample_cnt), 64'(CNT_MAX));

        // Clear coinciding with a delivery
        send(8'd15, 8'd15, 1'b1);
        repeat (STAGES - 1) @(posedge clk);
        #1;
        check("clr_dlv_out_valid", 64'(out_valid), 64'(1));
        pulse_clr();
        check("clr_dlv_err_acc", 64'(err_acc), 64'(0));
        check("clr_dlv_sample_cnt", 64'(sample_cnt), 64'(0));
        drain();

        // Reset with two transactions in flight
        send(8'd9, 8'd9, 1'b1);
        drain();
        out_ready = 1'b0;
        send(8'd100, 8'd100, 1'b1);
        send(8'd200, 8'd3, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_err_acc", 64'(err_acc), 64'(0));
        check("midrst_sample_cnt", 64'(sample_cnt), 64'(0));
        rst = 1'b0;
        out_ready = 1'b1;
        d0 = dlv_count;
        repeat (10) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(dlv_count - d0), 64'(0));

        // Random traffic with random backpressure
        done = 0;
        fork
            begin
                for (int n = 0; n < 150; n++) begin
                    if ($urandom_range(3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(W'($urandom_range(255)), W'($urandom_range(255)), 1'($urandom_range(1)));
                end
                done = 1;
            end
            while (!done) begin
                @(posedge clk);
                #1;
                out_ready = ($urandom_range(3) != 0);
            end
        join
        out_ready = 1'b1;
        drain();
        check("final_queue", 64'(q.size()), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
